// File: rtl/threewire_responder_if.sv
// Register-bank side of the 3-wire responder: decoded address, write data,
// strobes and busy toward the bank; read word back from it.
interface threewire_responder_if #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] out_addr;
    logic [DATA_BITS-1:0] out_wr_data;
    logic                 out_wr_strobe;
    logic                 out_rd_strobe;
    logic                 out_busy;
    logic [DATA_BITS-1:0] in_rd_data;

    modport master (
        output out_addr, out_wr_data, out_wr_strobe, out_rd_strobe, out_busy,
        input  in_rd_data
    );

    modport slave (
        input  out_addr, out_wr_data, out_wr_strobe, out_rd_strobe, out_busy,
        output in_rd_data
    );
endinterface

// File: rtl/threewire_responder.sv
// Responder end of the 3-wire serial bus: decodes write frames into a bank
// write strobe and answers read frames by shifting a bank word back on the line.
module threewire_responder #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_tw_clock,
    input  logic                   in_tw_cs,
    inout  wire                    io_tw_data,
    threewire_responder_if.master  bank
);
    localparam int CNT_W = $clog2(DATA_BITS > ADDR_BITS ? DATA_BITS : ADDR_BITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RW    = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [1:0] clk_sync_q, cs_sync_q, dat_sync_q;
    logic       clk_prev_q;

    // CS synchroniser resets to the idle (high) level so no phantom frame
    // starts while the chain fills after reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            clk_sync_q <= 2'b00;
            cs_sync_q  <= 2'b11;
            dat_sync_q <= 2'b00;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], in_tw_clock};
            cs_sync_q  <= {cs_sync_q[0], in_tw_cs};
            dat_sync_q <= {dat_sync_q[0], io_tw_data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    logic tw_clk, tw_cs, tw_dat, rise, fall;
    assign tw_clk = clk_sync_q[1];
    assign tw_cs  = cs_sync_q[1];
    assign tw_dat = dat_sync_q[1];
    assign rise   =  tw_clk & ~clk_prev_q & ~tw_cs;
    assign fall   = ~tw_clk &  clk_prev_q & ~tw_cs;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rw_q, rw_d;
    logic                 turn_q, turn_d;
    logic                 drive_q, drive_d;
    logic                 busy_q, busy_d;
    logic                 wr_stb_q, wr_stb_d;
    logic                 rd_stb_q, rd_stb_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    // NOTE: every always_comb output is given a default first so no path
    // through the case leaves it unassigned (no inferred latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        turn_d    = turn_q;
        drive_d   = drive_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;

        // CS high outranks any same-cycle clock edge: abort without strobes.
        if (state_q != S_IDLE && tw_cs) begin
            state_d = S_IDLE;
            drive_d = 1'b0;
            busy_d  = 1'b0;
            turn_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (!tw_cs) begin
                    state_d = S_RW;
                    busy_d  = 1'b1;
                end
                S_RW: if (rise) begin
                    rw_d    = tw_dat;
                    cnt_d   = CNT_W'(ADDR_BITS - 1);
                    state_d = S_ADDR;
                end
                S_ADDR: if (rise) begin
                    shift_d = {shift_q[DATA_BITS-2:0], tw_dat};
                    if (cnt_q == '0) begin
                        addr_d = {shift_q[ADDR_BITS-2:0], tw_dat};
                        if (rw_q) begin
                            cnt_d   = CNT_W'(DATA_BITS - 1);
                            state_d = S_WDATA;
                        end else begin
                            rd_stb_d = 1'b1;
                            turn_d   = 1'b0;
                            state_d  = S_TURN;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WDATA: if (rise) begin
                    shift_d = {shift_q[DATA_BITS-2:0], tw_dat};
                    if (cnt_q == '0) begin
                        wr_data_d = {shift_q[DATA_BITS-2:0], tw_dat};
                        wr_stb_d  = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // First fall captures the bank word; second fall starts driving.
                S_TURN: if (fall) begin
                    if (!turn_q) begin
                        shift_d = bank.in_rd_data;
                        turn_d  = 1'b1;
                    end else begin
                        drive_d = 1'b1;
                        cnt_d   = CNT_W'(DATA_BITS - 1);
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: if (fall) begin
                    if (cnt_q != '0) begin
                        shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        drive_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            turn_q    <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            turn_q    <= turn_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign io_tw_data         = drive_q ? shift_q[DATA_BITS-1] : 1'bz;
    assign bank.out_addr      = addr_q;
    assign bank.out_wr_data   = wr_data_q;
    assign bank.out_wr_strobe = wr_stb_q;
    assign bank.out_rd_strobe = rd_stb_q;
    assign bank.out_busy      = busy_q;
endmodule

// File: tb/tb_threewire_responder.sv
// Directed bench for threewire_responder: plays the initiator, models the
// register bank, and checks decoded strobes and read-back words.
module tb_threewire_responder;
    localparam int  AB   = 9;
    localparam int  DB   = 16;
    localparam time HALF = 40ns;

    logic in_clk = 1'b0;
    logic in_rst_n = 1'b0;
    logic tw_clock = 1'b0;
    logic tw_cs = 1'b1;
    logic tb_oe = 1'b0;
    logic tb_do = 1'b0;
    wire  tw_data;

    // Released line reads as 1, so a responder driving 0 while it should be Z shows up.
    pullup (tw_data);
    assign tw_data = tb_oe ? tb_do : 1'bz;

    always #5ns in_clk = ~in_clk;

    threewire_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bank ();

    threewire_responder #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_tw_clock (tw_clock),
        .in_tw_cs    (tw_cs),
        .io_tw_data  (tw_data),
        .bank        (bank.master)
    );

    logic [DB-1:0] bank_mem [0:(1<<AB)-1];
    logic          poke_en = 1'b0;
    logic [AB-1:0] poke_addr = '0;
    logic [DB-1:0] poke_data = '0;

    always @(posedge in_clk) begin
        if (poke_en) bank_mem[poke_addr] <= poke_data;
        else if (bank.out_wr_strobe) bank_mem[bank.out_addr] <= bank.out_wr_data;
    end
    assign bank.in_rd_data = bank_mem[bank.out_addr];

    int            wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int            last_kind = 0, prev_kind = 0;
    logic [AB-1:0] wr_addr_seen = '0, rd_addr_seen = '0;
    logic [DB-1:0] wr_data_seen = '0;

    always @(negedge in_clk) begin
        if (bank.out_wr_strobe && bank.out_rd_strobe) both_cnt++;
        if (bank.out_wr_strobe) begin
            wr_cnt++; wr_addr_seen = bank.out_addr; wr_data_seen = bank.out_wr_data;
            prev_kind = last_kind; last_kind = 1;
        end
        if (bank.out_rd_strobe) begin
            rd_cnt++; rd_addr_seen = bank.out_addr;
            prev_kind = last_kind; last_kind = 2;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
        @(negedge in_clk);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(negedge in_clk);
        poke_en = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        tb_do = b;
        #HALF tw_clock = 1'b1;
        #HALF tw_clock = 1'b0;
    endtask

    task automatic clock_pulse();
        #HALF tw_clock = 1'b1;
        #HALF tw_clock = 1'b0;
    endtask

    // Leaves CS low; `extra` bus clocks are issued after the line is released.
    task automatic write_frame(input logic [AB-1:0] a, input logic [DB-1:0] d, input int extra);
        tw_cs = 1'b0; tb_oe = 1'b1;
        #HALF;
        send_bit(1'b1);
        for (int i = AB-1; i >= 0; i--) send_bit(a[i]);
        for (int i = DB-1; i >= 0; i--) send_bit(d[i]);
        tb_oe = 1'b0;
        for (int i = 0; i < extra; i++) clock_pulse();
        #HALF;
    endtask

    // Samples each responder bit just before the fall that ends its period.
    task automatic read_frame(input logic [AB-1:0] a, input int n_bits,
                              output logic [DB-1:0] got, output logic turn_line);
        got = '0;
        tw_cs = 1'b0; tb_oe = 1'b1;
        #HALF;
        send_bit(1'b0);
        for (int i = AB-1; i >= 0; i--) send_bit(a[i]);
        tb_oe = 1'b0;
        #HALF tw_clock = 1'b1;
        #HALF turn_line = tw_data;
        tw_clock = 1'b0;
        for (int i = 0; i < n_bits; i++) begin
            #HALF tw_clock = 1'b1;
            #HALF got = {got[DB-2:0], tw_data};
            tw_clock = 1'b0;
        end
    endtask

    task automatic end_frame();
        tw_cs = 1'b1;
        #(2*HALF);
    endtask

    int            wr0, rd0;
    logic [DB-1:0] rdat;
    logic          tline;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #22ns;
        check("rst_addr",    32'(bank.out_addr), 32'h0);
        check("rst_wdata",   32'(bank.out_wr_data), 32'h0);
        check("rst_strobes", 32'({bank.out_wr_strobe, bank.out_rd_strobe}), 32'h0);
        check("rst_busy",    32'(bank.out_busy), 32'h0);
        check("rst_line",    32'(tw_data), 32'h1);
        @(negedge in_clk) in_rst_n = 1'b1;
        poke(9'h1FF, 16'h8001);
        poke(9'h002, 16'h0000);
        #(2*HALF);

        // Write 0x0A5 / 0xBEEF
        wr0 = wr_cnt; rd0 = rd_cnt;
        write_frame(9'h0A5, 16'hBEEF, 0);
        check("w1_busy_done", 32'(bank.out_busy), 32'h1);
        check("w1_line_done", 32'(tw_data), 32'h1);
        end_frame();
        check("w1_wr_cnt",    32'(wr_cnt - wr0), 32'd1);
        check("w1_rd_cnt",    32'(rd_cnt - rd0), 32'd0);
        check("w1_strb_addr", 32'(wr_addr_seen), 32'h0A5);
        check("w1_strb_data", 32'(wr_data_seen), 32'hBEEF);
        check("w1_addr",      32'(bank.out_addr), 32'h0A5);
        check("w1_wdata",     32'(bank.out_wr_data), 32'hBEEF);
        check("w1_busy_idle", 32'(bank.out_busy), 32'h0);

        // Read 0x1FF returning 0x8001
        wr0 = wr_cnt; rd0 = rd_cnt;
        read_frame(9'h1FF, DB, rdat, tline);
        check("r1_data",  32'(rdat), 32'h8001);
        check("r1_turn",  32'(tline), 32'h1);
        #HALF;
        check("r1_line_after", 32'(tw_data), 32'h1);
        end_frame();
        check("r1_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
        check("r1_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        check("r1_addr",   32'(rd_addr_seen), 32'h1FF);

        // Read of an all-zero word: a released line is distinguishable from a driven 0
        read_frame(9'h002, DB, rdat, tline);
        check("r0_data", 32'(rdat), 32'h0000);
        check("r0_turn", 32'(tline), 32'h1);
        #HALF;
        check("r0_line_after", 32'(tw_data), 32'h1);
        end_frame();

        // Back-to-back write then read of the same address
        wr0 = wr_cnt; rd0 = rd_cnt;
        write_frame(9'h001, 16'h1234, 0);
        end_frame();
        read_frame(9'h001, DB, rdat, tline);
        #HALF;
        end_frame();
        check("b2b_data",   32'(rdat), 32'h1234);
        check("b2b_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("b2b_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
        check("b2b_order",  32'({prev_kind[3:0], last_kind[3:0]}), 32'h12);

        // Abort after 5 address bits, then a full write
        wr0 = wr_cnt; rd0 = rd_cnt;
        tw_cs = 1'b0; tb_oe = 1'b1;
        #HALF;
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        tw_cs = 1'b1; tb_oe = 1'b0;
        repeat (3) @(posedge in_clk);
        #1ns;
        check("ab_busy",   32'(bank.out_busy), 32'h0);
        #(2*HALF);
        check("ab_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        check("ab_addr",    32'(bank.out_addr), 32'h001);
        write_frame(9'h155, 16'hA5A5, 0);
        end_frame();
        check("ab_w_addr",  32'(bank.out_addr), 32'h155);
        check("ab_w_wdata", 32'(bank.out_wr_data), 32'hA5A5);
        check("ab_w_cnt",   32'(wr_cnt - wr0), 32'd1);

        // Three extra bus clocks in DONE
        wr0 = wr_cnt; rd0 = rd_cnt;
        write_frame(9'h0F0, 16'h5A5A, 3);
        check("ex_line", 32'(tw_data), 32'h1);
        end_frame();
        check("ex_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("ex_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
        check("ex_wdata",  32'(bank.out_wr_data), 32'h5A5A);

        // Reset while the responder drives bit 7 (0) of 0x1234
        read_frame(9'h001, 8, rdat, tline);
        check("rr_upper", 32'(rdat[7:0]), 32'h12);
        #HALF;
        check("rr_driven0", 32'(tw_data), 32'h0);
        in_rst_n = 1'b0;
        #1ns;
        check("rr_line",  32'(tw_data), 32'h1);
        check("rr_addr",  32'(bank.out_addr), 32'h0);
        check("rr_wdata", 32'(bank.out_wr_data), 32'h0);
        check("rr_busy",  32'(bank.out_busy), 32'h0);
        check("rr_strb",  32'({bank.out_wr_strobe, bank.out_rd_strobe}), 32'h0);
        tw_cs = 1'b1;
        #(2*HALF);
        @(negedge in_clk) in_rst_n = 1'b1;
        #(2*HALF);
        rd0 = rd_cnt;
        read_frame(9'h1FF, DB, rdat, tline);
        #HALF;
        end_frame();
        check("rr_fresh_data", 32'(rdat), 32'h8001);
        check("rr_fresh_cnt",  32'(rd_cnt - rd0), 32'd1);
        check("never_both",    32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
